// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_driver
// Purpose  : Time-multiplexed scanner for a common-anode multi-digit hex
//            display. Captures a word into a shadow register on `load`,
//            walks its nibbles one digit slot at a time (PRESCALE cycles per
//            slot) and hands each nibble to the downstream 7-segment decoder.
//            Each slot opens with DEAD cycles of all-digits-off to suppress
//            ghosting; optional leading-zero blanking flags upper zero digits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising-edge active
//   reset      in   synchronous active-high reset
//   load       in   capture `data` into the shadow register on this edge
//   data       in   4*DIGITS bit word, nibble i = data[4i+3:4i], digit 0 right
//   lz_en      in   enable leading-zero blanking (sampled on each tick)
//   nibble     out  value of the digit currently presented
//   blank      out  1 = presented digit is blanked
//   digit_sel  out  active-low one-hot digit enable
//   frame      out  one-cycle pulse on the tick presenting digit DIGITS-1
// ============================================================================
module hex_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  lz_en,
  output logic [3:0]            nibble,
  output logic                  blank,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] c_dead    = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow_q,   shadow_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [IDX_W-1:0]    cur_q,      cur_d;
  logic [CNT_W-1:0]    dead_cnt_q, dead_cnt_d;
  logic [3:0]          nibble_q,   nibble_d;
  logic                blank_q,    blank_d;
  logic                frame_q,    frame_d;
  logic [DIGITS-1:0]   sel_q,      sel_d;
  // Set by the first tick; keeps every digit dark between reset and the
  // first slot, since cur=0/dead_cnt=0 would otherwise light digit 0.
  logic                active_q,   active_d;

  logic                w_tick;
  logic                w_upper_zero;

  always_comb begin
    w_tick = (cnt_q == c_cnt_max);

    shadow_d = load ? data : shadow_q;
    cnt_d    = w_tick ? '0 : cnt_q + 1'b1;

    // All nibbles from idx upward are zero in the pre-edge shadow.
    w_upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((IDX_W'(j) >= idx_q) && (shadow_q[4*j +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end

    idx_d      = idx_q;
    cur_d      = cur_q;
    nibble_d   = nibble_q;
    blank_d    = blank_q;
    frame_d    = 1'b0;
    active_d   = active_q;
    dead_cnt_d = (dead_cnt_q != '0) ? dead_cnt_q - 1'b1 : dead_cnt_q;

    if (w_tick) begin
      cur_d      = idx_q;
      nibble_d   = shadow_q[{idx_q, 2'b00} +: 4];
      blank_d    = lz_en && (idx_q != '0) && w_upper_zero;
      frame_d    = (idx_q == c_idx_max);
      idx_d      = (idx_q == c_idx_max) ? '0 : idx_q + 1'b1;
      dead_cnt_d = c_dead;
      active_d   = 1'b1;
    end

    // Select is computed from next-state values so the output is a flop
    // that already reflects the dead-time window on the tick edge.
    sel_d = '1;
    if (active_d && (dead_cnt_d == '0)) begin
      sel_d[cur_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      cur_q      <= '0;
      dead_cnt_q <= '0;
      nibble_q   <= 4'h0;
      blank_q    <= 1'b1;
      frame_q    <= 1'b0;
      sel_q      <= '1;
      active_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      dead_cnt_q <= dead_cnt_d;
      nibble_q   <= nibble_d;
      blank_q    <= blank_d;
      frame_q    <= frame_d;
      sel_q      <= sel_d;
      active_q   <= active_d;
    end
  end

  assign nibble    = nibble_q;
  assign blank     = blank_q;
  assign frame     = frame_q;
  assign digit_sel = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_scan_driver
// Purpose  : Directed bench for hex_scan_driver (DIGITS=8, PRESCALE=4).
//            Main instance uses DEAD=1; a second instance uses DEAD=0 for
//            slot/frame timing. Expected per-slot outputs are queued when
//            the data is chosen and popped at each tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] data;
  logic        lz_en;

  logic [3:0]  nibble,  nibble0;
  logic        blank,   blank0;
  logic [7:0]  sel,     sel0;
  logic        frame,   frame0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] nib;
    logic       blk;
    logic [7:0] sel;
    logic       frm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hex_scan_driver #(.DIGITS(8), .PRESCALE(4), .DEAD(1)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .lz_en(lz_en),
    .nibble(nibble), .blank(blank), .digit_sel(sel), .frame(frame)
  );

  hex_scan_driver #(.DIGITS(8), .PRESCALE(4), .DEAD(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .data(data), .lz_en(lz_en),
    .nibble(nibble0), .blank(blank0), .digit_sel(sel0), .frame(frame0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for n consecutive slots starting at digit `start`.
  function automatic void push_slots(input logic [31:0] d, input bit lz,
                                     input int start, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   i;
      i     = (start + k) % 8;
      e.idx = 3'(i);
      e.nib = d[4*i +: 4];
      e.blk = lz && (i != 0) && ((d >> (4*i)) == 32'h0);
      e.sel = ~(8'h01 << i);
      e.frm = (i == 7);
      sb.push_back(e);
    end
  endfunction

  task automatic check_tick(output logic [7:0] sel_exp);
    exp_t e;
    @(posedge clk); #1;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL sb_empty: observed 0 entries expected >0");
    end
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    sel_exp = e.sel;
    chk($sformatf("d%0d_nibble", e.idx), {28'h0, nibble}, {28'h0, e.nib});
    chk($sformatf("d%0d_blank", e.idx),  {31'h0, blank},  {31'h0, e.blk});
    chk($sformatf("d%0d_frame", e.idx),  {31'h0, frame},  {31'h0, e.frm});
    chk($sformatf("d%0d_sel_dead", e.idx), {24'h0, sel}, 32'hFF);
  endtask

  // One full slot. pre_load is held across the tick edge; mid_load is
  // captured on the edge after the tick.
  task automatic run_slot(input bit pre_load, input logic [31:0] pre_data,
                          input bit mid_load, input logic [31:0] mid_data,
                          input bit mid_lz);
    logic [7:0] se;
    if (pre_load) begin
      load = 1'b1;
      data = pre_data;
    end
    check_tick(se);
    load = mid_load;
    if (mid_load) begin
      data  = mid_data;
      lz_en = mid_lz;
    end
    @(posedge clk); #1;
    load = 1'b0;
    chk("slot_sel_on", {24'h0, sel}, {24'h0, se});
    chk("slot_frame_low", {31'h0, frame}, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("slot_sel_hold", {24'h0, sel}, {24'h0, se});
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_nibble"}, {28'h0, nibble}, 32'h0);
    chk({tag, "_blank"},  {31'h0, blank},  32'h1);
    chk({tag, "_sel"},    {24'h0, sel},    32'hFF);
    chk({tag, "_frame"},  {31'h0, frame},  32'h0);
    chk({tag, "_sel0"},   {24'h0, sel0},   32'hFF);
    chk({tag, "_blank0"}, {31'h0, blank0}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_chg;
    int last_frm;
    int nfrm;
    logic [7:0] prev_sel;

    reset = 1'b1; load = 1'b0; data = 32'h0; lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");

    // Release reset and load on the first edge after it.
    reset = 1'b0; load = 1'b1; data = 32'h1234ABCD;
    @(posedge clk); #1;
    load = 1'b0;
    chk("prefirst_sel", {24'h0, sel}, 32'hFF);
    repeat (2) begin
      @(posedge clk); #1;
      chk("prefirst_sel", {24'h0, sel}, 32'hFF);
      chk("prefirst_nibble", {28'h0, nibble}, 32'h0);
    end

    // Full frame plus wrap back to digit 0; then load 0xA0 with blanking.
    push_slots(32'h1234ABCD, 1'b0, 0, 9);
    repeat (8) run_slot(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    run_slot(1'b0, 32'h0, 1'b1, 32'h000000A0, 1'b1);

    push_slots(32'h000000A0, 1'b1, 1, 8);
    repeat (7) run_slot(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    run_slot(1'b0, 32'h0, 1'b1, 32'h00000000, 1'b1);

    push_slots(32'h00000000, 1'b1, 1, 8);
    repeat (7) run_slot(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    run_slot(1'b0, 32'h0, 1'b1, 32'h00F00000, 1'b1);

    push_slots(32'h00F00000, 1'b1, 1, 8);
    repeat (7) run_slot(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    run_slot(1'b0, 32'h0, 1'b1, 32'h11111111, 1'b1);

    // Load coinciding with a tick: that tick still shows the old value.
    push_slots(32'h11111111, 1'b1, 1, 1);
    run_slot(1'b1, 32'h22222222, 1'b0, 32'h0, 1'b1);
    push_slots(32'h22222222, 1'b1, 2, 4);
    repeat (3) run_slot(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset for one cycle during the slot presenting digit 5.
    begin
      logic [7:0] se;
      check_tick(se);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("midreset");
    repeat (3) begin
      @(posedge clk); #1;
      chk("midreset_sel_wait", {24'h0, sel}, 32'hFF);
    end
    push_slots(32'h00000000, 1'b1, 0, 2);
    repeat (2) run_slot(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // DEAD=0 instance: always one digit on, 4-cycle slots, 32-cycle frames.
    prev_sel = sel0;
    last_chg = -1;
    last_frm = -1;
    nfrm     = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      chk("dead0_onehot", $countones(~sel0), 32'd1);
      if (sel0 != prev_sel) begin
        if (last_chg >= 0) chk("dead0_slot_len", c - last_chg, 32'd4);
        last_chg = c;
        prev_sel = sel0;
      end
      if (frame0) begin
        if (last_frm >= 0) chk("dead0_frame_period", c - last_frm, 32'd32);
        last_frm = c;
        nfrm++;
      end
    end
    chk("dead0_frames_seen", {31'h0, (nfrm >= 2)}, 32'h1);
    chk("sb_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
